// File: rtl/lift_pkg.sv
// Shared types and constants for the lift cabin/door sequencer.
package lift_pkg;

    typedef enum logic [1:0] {
        AT_FLOOR   = 2'd0,
        TRAVEL     = 2'd1,
        DOOR_OPEN  = 2'd2,
        DOOR_GUARD = 2'd3
    } cabin_state_t;

    localparam int   DOOR_GUARD_CYCLES = 4;
    localparam logic DIR_UP            = 1'b1;
    localparam logic DIR_DN            = 1'b0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lift_down_counter.sv
// Loadable down-counter; zero_o flags the cycle in which a decrement lands on zero.
module lift_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    // Flag the terminal step so the owner changes state on the same edge the count hits zero.
    assign zero_o = dec_i && (cnt_q == WIDTH'(1));

endmodule

// File: rtl/lift_cabin_ctrl.sv
// Cabin travel and door sequencer closing the loop with the lift decision stage.
// Optional door reopen/hold input is enabled by defining LIFT_DOOR_REOPEN_EN.
module lift_cabin_ctrl
    import lift_pkg::*;
#(
    parameter int N_FLOORS         = 8,
    parameter int TRAVEL_CYCLES    = 16,
    parameter int DOOR_OPEN_CYCLES = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_motion,
    input  logic                        i_direction,
    input  logic                        i_has_rqst_at_stopped_flr,
`ifdef LIFT_DOOR_REOPEN_EN
    input  logic                        i_door_hold,
`endif
    output logic [N_FLOORS-1:0]         o_flr_pos,
    output logic [$clog2(N_FLOORS)-1:0] o_floor_idx,
    output logic                        o_door_open,
    output logic                        o_busy,
    output logic                        o_limit_err
);

    localparam int IDX_W = $clog2(N_FLOORS);
    localparam int TMR_W = $clog2(max3(TRAVEL_CYCLES, DOOR_OPEN_CYCLES, DOOR_GUARD_CYCLES) + 1);
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(N_FLOORS - 1);

    cabin_state_t          state_q;
    logic [IDX_W-1:0]      idx_q;
    logic [N_FLOORS-1:0]   pos_q;
    logic                  door_q;
    logic                  busy_q;
    logic                  lim_q;
    logic                  dir_q;

    logic [IDX_W-1:0]      next_idx_d;
    logic                  move_legal;
    logic                  door_hold;
    logic                  tmr_load;
    logic [TMR_W-1:0]      tmr_val;
    logic                  tmr_dec;
    logic                  tmr_zero;

`ifdef LIFT_DOOR_REOPEN_EN
    assign door_hold = i_door_hold;
`else
    assign door_hold = 1'b0;
`endif

    always_comb begin
        next_idx_d = (dir_q == DIR_UP) ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);
        move_legal = (i_direction == DIR_UP) ? (idx_q != TOP_IDX) : (idx_q != '0);
    end

    // Every timed state counts down; a load overrides the decrement in the counter.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = (state_q != AT_FLOOR);
        case (state_q)
            AT_FLOOR: begin
                if (i_has_rqst_at_stopped_flr) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(DOOR_OPEN_CYCLES);
                end else if (i_motion && move_legal) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(TRAVEL_CYCLES);
                end
            end
            DOOR_OPEN: begin
                if (door_hold) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(DOOR_OPEN_CYCLES);
                end else if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(DOOR_GUARD_CYCLES);
                end
            end
            DOOR_GUARD: begin
                if (door_hold) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(DOOR_OPEN_CYCLES);
                end
            end
            default: begin
            end
        endcase
    end

    lift_down_counter #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= AT_FLOOR;
            idx_q   <= '0;
            pos_q   <= N_FLOORS'(1);
            door_q  <= 1'b0;
            busy_q  <= 1'b0;
            lim_q   <= 1'b0;
            dir_q   <= DIR_DN;
        end else begin
            lim_q <= 1'b0;
            case (state_q)
                AT_FLOOR: begin
                    // Door request beats motion; motion is re-sampled after the guard.
                    if (i_has_rqst_at_stopped_flr) begin
                        state_q <= DOOR_OPEN;
                        door_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (i_motion) begin
                        if (move_legal) begin
                            state_q <= TRAVEL;
                            busy_q  <= 1'b1;
                            pos_q   <= '0;
                            dir_q   <= i_direction;
                        end else begin
                            lim_q <= 1'b1;
                        end
                    end
                end
                TRAVEL: begin
                    if (tmr_zero) begin
                        state_q <= AT_FLOOR;
                        busy_q  <= 1'b0;
                        idx_q   <= next_idx_d;
                        pos_q   <= N_FLOORS'(1) << next_idx_d;
                    end
                end
                DOOR_OPEN: begin
                    if (!door_hold && tmr_zero) begin
                        state_q <= DOOR_GUARD;
                        door_q  <= 1'b0;
                    end
                end
                DOOR_GUARD: begin
                    if (door_hold) begin
                        state_q <= DOOR_OPEN;
                        door_q  <= 1'b1;
                    end else if (tmr_zero) begin
                        state_q <= AT_FLOOR;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= AT_FLOOR;
                end
            endcase
        end
    end

    assign o_flr_pos   = pos_q;
    assign o_floor_idx = idx_q;
    assign o_door_open = door_q;
    assign o_busy      = busy_q;
    assign o_limit_err = lim_q;

endmodule

// File: tb/tb_lift_cabin_ctrl.sv
// Scoreboard bench for lift_cabin_ctrl with a cycle model; hold scenario runs when LIFT_DOOR_REOPEN_EN is defined.
module tb_lift_cabin_ctrl;

    localparam int NF = 4;
    localparam int TC = 3;
    localparam int DC = 5;
    localparam int GC = 4;

    localparam int S_AT = 0;
    localparam int S_TR = 1;
    localparam int S_DO = 2;
    localparam int S_DG = 3;

    typedef struct packed {
        logic [3:0] pos;
        logic [1:0] idx;
        logic       door;
        logic       busy;
        logic       lim;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       motion = 1'b0;
    logic       dir = 1'b0;
    logic       rqst = 1'b0;
`ifdef LIFT_DOOR_REOPEN_EN
    logic       hold = 1'b0;
`endif
    logic [3:0] o_flr_pos;
    logic [1:0] o_floor_idx;
    logic       o_door_open;
    logic       o_busy;
    logic       o_limit_err;

    always #5 clk = ~clk;

    lift_cabin_ctrl #(
        .N_FLOORS         (NF),
        .TRAVEL_CYCLES    (TC),
        .DOOR_OPEN_CYCLES (DC)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .i_motion                  (motion),
        .i_direction               (dir),
        .i_has_rqst_at_stopped_flr (rqst),
`ifdef LIFT_DOOR_REOPEN_EN
        .i_door_hold               (hold),
`endif
        .o_flr_pos                 (o_flr_pos),
        .o_floor_idx               (o_floor_idx),
        .o_door_open               (o_door_open),
        .o_busy                    (o_busy),
        .o_limit_err               (o_limit_err)
    );

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    int   m_state = S_AT;
    int   m_idx = 0;
    int   m_rem = 0;
    int   m_dir = 0;
    logic m_lim = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: m_rem is the number of cycles still to spend in the current state.
    task automatic model_step(input logic mo, input logic di, input logic rq, input logic ho, input logic rs);
        if (rs) begin
            m_state = S_AT; m_idx = 0; m_rem = 0; m_lim = 1'b0;
        end else begin
            m_lim = 1'b0;
            case (m_state)
                S_AT: begin
                    if (rq) begin
                        m_state = S_DO; m_rem = DC;
                    end else if (mo) begin
                        if ((di && m_idx == NF - 1) || (!di && m_idx == 0)) m_lim = 1'b1;
                        else begin
                            m_state = S_TR; m_rem = TC; m_dir = di ? 1 : -1;
                        end
                    end
                end
                S_TR: begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_idx = m_idx + m_dir; m_state = S_AT;
                    end
                end
                S_DO: begin
                    if (ho) m_rem = DC;
                    else begin
                        m_rem--;
                        if (m_rem == 0) begin
                            m_state = S_DG; m_rem = GC;
                        end
                    end
                end
                default: begin
                    if (ho) begin
                        m_state = S_DO; m_rem = DC;
                    end else begin
                        m_rem--;
                        if (m_rem == 0) m_state = S_AT;
                    end
                end
            endcase
        end
    endtask

    task automatic cycle(input logic mo, input logic di, input logic rq, input logic ho, input logic rs);
        exp_t e;
        logic ho_eff;
        @(negedge clk);
        motion = mo; dir = di; rqst = rq; reset = rs;
`ifdef LIFT_DOOR_REOPEN_EN
        hold = ho;
        ho_eff = ho;
`else
        ho_eff = 1'b0 & ho;
`endif
        model_step(mo, di, rq, ho_eff, rs);
        e.pos  = (m_state == S_TR) ? 4'b0000 : 4'(1 << m_idx);
        e.idx  = 2'(m_idx);
        e.door = (m_state == S_DO);
        e.busy = (m_state != S_AT);
        e.lim  = m_lim;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("flr_pos", 32'(o_flr_pos), 32'(e.pos));
        check_eq("floor_idx", 32'(o_floor_idx), 32'(e.idx));
        check_eq("door_open", 32'(o_door_open), 32'(e.door));
        check_eq("busy", 32'(o_busy), 32'(e.busy));
        check_eq("limit_err", 32'(o_limit_err), 32'(e.lim));
    endtask

    initial begin
        int door_cnt;
        int stay_cnt;

        // Reset then idle
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check_eq("rst_pos", 32'(o_flr_pos), 32'b0001);
        check_eq("rst_idx", 32'(o_floor_idx), 0);
        check_eq("rst_door", 32'(o_door_open), 0);
        check_eq("rst_busy", 32'(o_busy), 0);

        // Climb to the top floor with motion held up
        for (int k = 0; k < 3; k++) begin
            cycle(1, 1, 0, 0, 0);
            check_eq("transit_pos", 32'(o_flr_pos), 0);
            for (int j = 0; j < 3; j++) cycle(1, 1, 0, 0, 0);
            check_eq("arrive_pos", 32'(o_flr_pos), 32'b0010 << k);
        end
        cycle(1, 1, 0, 0, 0);
        check_eq("top_limit", 32'(o_limit_err), 1);
        check_eq("top_pos", 32'(o_flr_pos), 32'b1000);
        cycle(0, 1, 0, 0, 0);
        check_eq("limit_pulse_end", 32'(o_limit_err), 0);

        // Down to floor 1, then door request together with motion
        for (int j = 0; j < 8; j++) cycle(1, 0, 0, 0, 0);
        check_eq("floor1_pos", 32'(o_flr_pos), 32'b0010);
        door_cnt = 0;
        stay_cnt = 0;
        cycle(1, 1, 1, 0, 0);
        door_cnt += int'(o_door_open);
        stay_cnt += int'(o_flr_pos == 4'b0010);
        for (int j = 0; j < 9; j++) begin
            cycle(1, 1, 0, 0, 0);
            door_cnt += int'(o_door_open);
            stay_cnt += int'(o_flr_pos == 4'b0010);
        end
        check_eq("door_open_len", door_cnt, DC);
        check_eq("no_travel_in_door", stay_cnt, 10);
        check_eq("guard_done_busy", 32'(o_busy), 0);
        cycle(1, 1, 0, 0, 0);
        check_eq("motion_after_guard", 32'(o_flr_pos), 0);
        for (int j = 0; j < 3; j++) cycle(0, 0, 0, 0, 0);
        check_eq("floor2_pos", 32'(o_flr_pos), 32'b0100);

        // Reset in the middle of a travel
        cycle(1, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        check_eq("midtravel_rst_pos", 32'(o_flr_pos), 32'b0001);
        check_eq("midtravel_rst_idx", 32'(o_floor_idx), 0);
        check_eq("midtravel_rst_busy", 32'(o_busy), 0);
        cycle(0, 0, 0, 0, 0);

        // Request held through the guard: no reopen until back at the floor
        door_cnt = 0;
        for (int j = 0; j < 5; j++) begin
            cycle(0, 0, 1, 0, 0);
            door_cnt += int'(o_door_open);
        end
        stay_cnt = 0;
        for (int j = 0; j < 5; j++) begin
            cycle(0, 0, 1, 0, 0);
            stay_cnt += int'(o_door_open);
        end
        check_eq("held_rqst_open", door_cnt, DC);
        check_eq("held_rqst_guard", stay_cnt, 0);
        cycle(0, 0, 1, 0, 0);
        check_eq("held_rqst_reopen", 32'(o_door_open), 1);
        for (int j = 0; j < 12; j++) cycle(0, 0, 0, 0, 0);

`ifdef LIFT_DOOR_REOPEN_EN
        // Hold at open cycle 4 and at guard cycle 2
        door_cnt = 0;
        cycle(0, 0, 1, 0, 0);
        door_cnt += int'(o_door_open);
        for (int i = 1; i <= 25; i++) begin
            cycle(0, 0, 0, (i == 4 || i == 11), 0);
            door_cnt += int'(o_door_open);
        end
        check_eq("hold_total_open", door_cnt, 14);
`endif

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 63) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
